// File: rtl/timetag_fifo_if.sv
// Push/pop handshake and status bundle for the time-tag FIFO.
// The master drives requests; the slave (the FIFO) drives data and status.
interface timetag_fifo_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int DROP_WIDTH = 16
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic                  clr_flags;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;
   logic [DROP_WIDTH-1:0] drop_count;

   modport master (
      output wr_en, din, rd_en, clr_flags,
      input  dout, dout_valid, full, empty,
      input  almost_full, almost_empty, count,
      input  overflow, underflow, drop_count
   );

   modport slave (
      input  wr_en, din, rd_en, clr_flags,
      output dout, dout_valid, full, empty,
      output almost_full, almost_empty, count,
      output overflow, underflow, drop_count
   );
endinterface

// File: rtl/timetag_fifo.sv
// Parametrised synchronous FIFO for time-tag words, standard or FWFT read,
// with almost-full/empty thresholds, sticky error flags and a drop counter.
module timetag_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_THRESH  = 12,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0,
   parameter int DROP_WIDTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   timetag_fifo_if.slave   f
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   cnt;
   logic                  full;
   logic                  empty;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  push_rej;
   logic                  pop_rej;
   logic                  ovf_q;
   logic                  udf_q;
   logic [DROP_WIDTH-1:0] drop_q;

   assign full     = (cnt == DEPTH_C);
   assign empty    = (cnt == '0);
   assign push_ok  = f.wr_en && !full;
   assign pop_ok   = f.rd_en && !empty;
   assign push_rej = f.wr_en && full;
   assign pop_rej  = f.rd_en && empty;

   assign f.full         = full;
   assign f.empty        = empty;
   assign f.almost_full  = (cnt >= AF_C);
   assign f.almost_empty = (cnt <= AE_C);
   assign f.count        = cnt;
   assign f.overflow     = ovf_q;
   assign f.underflow    = udf_q;
   assign f.drop_count   = drop_q;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= f.din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // A clear keeps the error seen in the same cycle; it only wipes history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
         drop_q <= '0;
      end else if (f.clr_flags) begin
         ovf_q  <= push_rej;
         udf_q  <= pop_rej;
         drop_q <= push_rej ? DROP_WIDTH'(1) : '0;
      end else begin
         if (push_rej) ovf_q <= 1'b1;
         if (pop_rej)  udf_q <= 1'b1;
         if (push_rej && !(&drop_q)) drop_q <= drop_q + 1'b1;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign f.dout       = empty ? '0 : mem[rd_ptr];
         assign f.dout_valid = !empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;
         logic                  dv_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout_q <= '0;
               dv_q   <= 1'b0;
            end else begin
               dv_q <= pop_ok;
               if (pop_ok) dout_q <= mem[rd_ptr];
            end
         end

         assign f.dout       = dout_q;
         assign f.dout_valid = dv_q;
      end
   endgenerate
endmodule
